// File: rtl/fp32_divider.sv
// Iterative binary32 divider: restoring division, one quotient bit per cycle, IEEE rounding + RISC-V fflags.
// Optional gradual underflow via FP32_DIVIDER_SUBNORMAL_EN; without it subnormals flush to signed zero.
module fp32_divider #(
  parameter int ITERATIONS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  roundingMode,
  input  logic [31:0] fpSrc1,
  input  logic [31:0] fpSrc2,
  input  logic        flush,
  output logic        resultValid,
  input  logic        resultReady,
  output logic [31:0] fpResult,
  output logic [4:0]  flags
);
  // state  | meaning
  // IDLE   | waiting for request, reqReady=1
  // UNPACK | classify operands, resolve specials, set up exponent/remainder
  // DIVIDE | one restoring step per cycle
  // ROUND  | normalize, round, pack
  // DONE   | result held until consumer takes it
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
  localparam int CW = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  state_t                state;
  logic [31:0]           a, b;
  logic [2:0]            rm;
  logic                  sign;
  logic signed [9:0]     exp_q;
  logic [23:0]           dvsr;
  logic [24:0]           rem;
  logic [ITERATIONS-1:0] quo;
  logic [CW-1:0]         cnt;

  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              nan_a, nan_b, snan, inf_a, inf_b, zero_a, zero_b, sign_ab;
  logic [23:0]       ma, mb;
  logic signed [9:0] xa, xb;

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign fa      = a[22:0];
  assign fb      = b[22:0];
  assign sign_ab = a[31] ^ b[31];
  assign nan_a   = (ea == 8'hFF) && (fa != 23'd0);
  assign nan_b   = (eb == 8'hFF) && (fb != 23'd0);
  assign snan    = (nan_a && !fa[22]) || (nan_b && !fb[22]);
  assign inf_a   = (ea == 8'hFF) && (fa == 23'd0);
  assign inf_b   = (eb == 8'hFF) && (fb == 23'd0);

`ifdef FP32_DIVIDER_SUBNORMAL_EN
  // Shift that brings the leading one of a subnormal fraction up to the hidden-bit position.
  function automatic logic [4:0] lead_shift(input logic [22:0] f);
    lead_shift = 5'd0;
    for (int i = 0; i < 23; i++)
      if (f[i]) lead_shift = 5'(23 - i);
  endfunction

  logic [4:0] sha, shb;
  assign sha    = lead_shift(fa);
  assign shb    = lead_shift(fb);
  assign zero_a = (ea == 8'd0) && (fa == 23'd0);
  assign zero_b = (eb == 8'd0) && (fb == 23'd0);
  assign ma     = (ea == 8'd0) ? ({1'b0, fa} << sha) : {1'b1, fa};
  assign mb     = (eb == 8'd0) ? ({1'b0, fb} << shb) : {1'b1, fb};
  assign xa     = (ea == 8'd0) ? (10'sd1 - $signed({5'd0, sha})) : $signed({2'b00, ea});
  assign xb     = (eb == 8'd0) ? (10'sd1 - $signed({5'd0, shb})) : $signed({2'b00, eb});
`else
  assign zero_a = (ea == 8'd0);
  assign zero_b = (eb == 8'd0);
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign xa     = $signed({2'b00, ea});
  assign xb     = $signed({2'b00, eb});
`endif

  logic        special;
  logic [31:0] spec_res;
  logic [4:0]  spec_flags;

  always_comb begin
    special    = 1'b1;
    spec_flags = 5'd0;
    spec_res   = {sign_ab, 31'd0};
    if (nan_a || nan_b) begin
      spec_res   = 32'h7FC0_0000;
      spec_flags = {snan, 4'd0};
    end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
      spec_res   = 32'h7FC0_0000;
      spec_flags = 5'b10000;
    end else if (inf_a) begin
      spec_res   = {sign_ab, 8'hFF, 23'd0};
    end else if (zero_b) begin
      spec_res   = {sign_ab, 8'hFF, 23'd0};
      spec_flags = 5'b01000;
    end else if (!(inf_b || zero_a)) begin
      special    = 1'b0;
    end
  end

  logic        ge;
  logic [24:0] sub;
  assign ge  = rem >= {1'b0, dvsr};
  assign sub = rem - {1'b0, dvsr};

  logic signed [9:0] exp_n, exp_r;
  logic [23:0]       sig;
  logic              grd, stk, den, inc, inexact;
  logic [24:0]       sum;
  logic [31:0]       rnd_res;
  logic [4:0]        rnd_flags;
`ifdef FP32_DIVIDER_SUBNORMAL_EN
  logic [4:0]        dsh;
  logic [24:0]       vec_sh;
`endif

  always_comb begin
    exp_n = quo[25] ? exp_q : exp_q - 10'sd1;
    sig   = quo[25] ? quo[25:2] : quo[24:1];
    grd   = quo[25] ? quo[1] : quo[0];
    stk   = (rem != 25'd0) | (quo[25] & quo[0]);
    den   = 1'b0;
`ifdef FP32_DIVIDER_SUBNORMAL_EN
    dsh    = 5'd0;
    vec_sh = {sig, grd};
    if (exp_n <= 10'sd0) begin
      den    = 1'b1;
      dsh    = (exp_n < -10'sd23) ? 5'd25 : 5'(10'sd1 - exp_n);
      vec_sh = {sig, grd} >> dsh;
      stk    = stk | (({sig, grd} & ((25'd1 << dsh) - 25'd1)) != 25'd0);
      sig    = vec_sh[24:1];
      grd    = vec_sh[0];
    end
`endif
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & (grd | stk);
      3'd3:    inc = ~sign & (grd | stk);
      3'd4:    inc = grd;
      default: inc = grd & (stk | sig[0]);
    endcase
    sum     = {1'b0, sig} + {24'd0, inc};
    // A denormalized significand that rounds up into the hidden bit becomes the smallest normal.
    exp_r   = den ? $signed({9'd0, sum[23]}) : (sum[24] ? exp_n + 10'sd1 : exp_n);
    inexact = grd | stk;
    rnd_res   = {sign, exp_r[7:0], sum[22:0]};
    rnd_flags = {4'd0, inexact};
    if (exp_r >= 10'sd255) begin
      rnd_flags = 5'b00101;
      case (rm)
        3'd1:    rnd_res = {sign, 31'h7F7F_FFFF};
        3'd2:    rnd_res = sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        3'd3:    rnd_res = sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: rnd_res = {sign, 8'hFF, 23'd0};
      endcase
    end
`ifdef FP32_DIVIDER_SUBNORMAL_EN
    else if (den && !sum[23] && inexact) begin
      rnd_flags = 5'b00011;
    end
`else
    else if (exp_r <= 10'sd0) begin
      rnd_res   = {sign, 31'd0};
      rnd_flags = 5'b00011;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      reqReady    <= 1'b1;
      resultValid <= 1'b0;
      fpResult    <= 32'd0;
      flags       <= 5'd0;
      a           <= 32'd0;
      b           <= 32'd0;
      rm          <= 3'd0;
      sign        <= 1'b0;
      exp_q       <= 10'sd0;
      dvsr        <= 24'd0;
      rem         <= 25'd0;
      quo         <= '0;
      cnt         <= '0;
    end else if (flush && state != IDLE) begin
      state       <= IDLE;
      reqReady    <= 1'b1;
      resultValid <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          a        <= fpSrc1;
          b        <= fpSrc2;
          rm       <= roundingMode;
          reqReady <= 1'b0;
          state    <= UNPACK;
        end
        UNPACK: begin
          sign <= sign_ab;
          if (special) begin
            fpResult    <= spec_res;
            flags       <= spec_flags;
            resultValid <= 1'b1;
            state       <= DONE;
          end else begin
            exp_q <= xa - xb + 10'sd127;
            rem   <= {1'b0, ma};
            dvsr  <= mb;
            quo   <= '0;
            cnt   <= '0;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          quo <= {quo[ITERATIONS-2:0], ge};
          rem <= (ge ? sub : rem) << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= ROUND;
        end
        ROUND: begin
          fpResult    <= rnd_res;
          flags       <= rnd_flags;
          resultValid <= 1'b1;
          state       <= DONE;
        end
        DONE: if (resultReady) begin
          resultValid <= 1'b0;
          reqReady    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
